// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 signed max pooling over a raster-order
// feature map. Each even row is reduced horizontally into a half-width line buffer.
// Each odd row combines that buffer with its own horizontal maxima to emit pooled
// elements through a single-entry valid/ready output register.
// Optional build macro: MAXPOOL_FUSED_RELU_EN clamps negative pooled results to 0.
module maxpool2x2_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic signed [DATA_WIDTH-1:0] pair_q;
    logic signed [DATA_WIDTH-1:0] lb_q [HALF_W];

    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;

    logic                         in_fire, out_fire;
    logic                         col_end, row_end, col_odd, row_odd;
    logic                         load_out;
    logic [IDX_W-1:0]             lb_idx;
    logic signed [DATA_WIDTH-1:0] cur, hmax, vmax, pooled;

    // The output register can take a new value whenever it is empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign col_end = (col_q == COL_W'(IMG_W - 1));
    assign row_end = (row_q == ROW_W'(IMG_H - 1));
    assign col_odd = col_q[0];
    assign row_odd = row_q[0];
    assign lb_idx  = IDX_W'(col_q >> 1);

    // Horizontal and vertical signed maxima for the element being accepted.
    always_comb begin
        cur  = $signed(in_data);
        hmax = (cur > pair_q) ? cur : pair_q;
        vmax = (hmax > lb_q[lb_idx]) ? hmax : lb_q[lb_idx];
`ifdef MAXPOOL_FUSED_RELU_EN
        pooled = vmax[DATA_WIDTH-1] ? '0 : vmax;
`else
        pooled = vmax;
`endif
    end

    // Bottom-right element of a 2x2 window produces a pooled output.
    assign load_out = in_fire && col_odd && row_odd;

    // Raster position counters: col wraps at the row end, row wraps at the frame end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_fire) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Output register next state: a new load wins over a drain, so no bubble appears.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = pooled;
            out_last_d  = row_end && col_end;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            if (in_fire && !col_odd) begin
                pair_q <= cur;
            end
        end
    end

    // Line buffer of horizontal maxima from even rows; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && in_fire && col_odd && !row_odd) begin
            lb_q[lb_idx] <= hmax;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream on a 4x4 map: expected pooled values are
// computed from each frame and queued before the frame is driven, then popped as
// the DUT completes output transfers.
module tb_maxpool2x2_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DW-1:0]        in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 out_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW:0]          exp_q[$];
    logic [DW:0]          mon_e;
    logic signed [DW-1:0] frame_buf[NPIX];
    bit                   hold = 1'b1;
    bit                   rand_ready = 1'b0;

    maxpool2x2_stream #(
        .DATA_WIDTH(DW),
        .IMG_W     (W),
        .IMG_H     (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int smax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference model: pooled value of each 2x2 block of frame_buf, in raster order.
    task automatic push_frame_expect();
        int m;
        logic [DW-1:0] v;
        logic last;
        for (int r = 0; r < H; r += 2) begin
            for (int c = 0; c < W; c += 2) begin
                m = smax(smax(int'(frame_buf[r*W+c]),     int'(frame_buf[r*W+c+1])),
                         smax(int'(frame_buf[(r+1)*W+c]), int'(frame_buf[(r+1)*W+c+1])));
`ifdef MAXPOOL_FUSED_RELU_EN
                if (m < 0) m = 0;
`endif
                v = DW'(m);
                last = (r == H - 2) && (c == W - 2);
                exp_q.push_back({last, v});
            end
        end
    endtask

    // Send the first n elements of frame_buf, optionally with random in_valid gaps.
    task automatic drive_frame(input bit rand_valid, input int n);
        int  cycles;
        bit  acc;
        for (int i = 0; i < n; i++) begin
            cycles = 0;
            do begin
                @(posedge clk);
                #1;
                in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = frame_buf[i];
                @(negedge clk);
                acc = in_valid && in_ready;
                cycles++;
            end while (!acc && cycles < 500);
            if (!acc) begin
                check_eq("in_accept_timeout", 0, 1);
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Downstream ready: held low on request, otherwise always-on or random.
    always @(posedge clk) begin
        #1;
        if (hold) out_ready = 1'b0;
        else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    // Output monitor: a transfer seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("out_data", int'(out_data), int'($signed(mon_e[DW-1:0])));
                check_eq("out_last", int'(out_last), int'(mon_e[DW]));
            end
        end
    end

    initial begin
        logic signed [DW-1:0] saved;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_last", int'(out_last), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);

        // Ramp 0..15 with out_ready=1 -> 5,7,13,15
        hold = 1'b0;
        for (int i = 0; i < NPIX; i++) frame_buf[i] = DW'(i);
        push_frame_expect();
        drive_frame(1'b0, NPIX);
        drain("drain_ramp");

        // Negative block in the top-left window
        for (int i = 0; i < NPIX; i++) frame_buf[i] = DW'(i);
        frame_buf[0] = -8'sd128;
        frame_buf[1] = -8'sd3;
        frame_buf[4] = -8'sd7;
        frame_buf[5] = -8'sd50;
        frame_buf[2] = -8'sd9;
        frame_buf[3] = -8'sd9;
        frame_buf[6] = -8'sd9;
        frame_buf[7] = -8'sd9;
        push_frame_expect();
        drive_frame(1'b0, NPIX);
        drain("drain_negative");

        // Backpressure: out_ready low for 5 cycles while an output is pending
        hold = 1'b1;
        for (int i = 0; i < NPIX; i++) frame_buf[i] = DW'((i * 37 + 11) % 256);
        push_frame_expect();
        fork
            drive_frame(1'b0, NPIX);
            begin
                seen = 1'b0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check_eq("stall_out_valid_seen", int'(seen), 1);
                saved = out_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", int'(in_ready), 0);
                    check_eq("stall_out_data", int'(out_data), int'(saved));
                end
                hold = 1'b0;
            end
        join
        drain("drain_stall");

        // Reset mid-frame after 6 inputs, then a clean frame
        hold = 1'b1;
        for (int i = 0; i < NPIX; i++) frame_buf[i] = DW'(i);
        drive_frame(1'b0, 6);
        @(negedge clk);
        check_eq("partial_pending_valid", int'(out_valid), 1);
        check_eq("partial_pending_data", int'(out_data), 5);
        do_reset();
        @(negedge clk);
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_out_data", int'(out_data), 0);
        check_eq("midrst_out_last", int'(out_last), 0);
        hold = 1'b0;
        push_frame_expect();
        drive_frame(1'b0, NPIX);
        drain("drain_after_rst");

        // Three back-to-back random frames with random valid/ready
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) frame_buf[i] = DW'($urandom_range(0, 255));
            push_frame_expect();
            drive_frame(1'b1, NPIX);
        end
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of one signed two's-complement element.
REQ-002 SHALL have parameter IMG_W, default 28: input feature-map width in elements; even, >= 2.
REQ-003 SHALL have parameter IMG_H, default 28: input feature-map height in rows; even, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  signed element, raster order (row-major, column 0 first).
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  signed pooled element.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_last  output  1  out_data is the final pooled element of a frame.

Function
REQ-013 SHALL compute non-overlapping 2x2 max pooling, stride 2, producing (IMG_W/2)*(IMG_H/2) outputs per IMG_W*IMG_H inputs, in raster order.
REQ-014 SHALL complete an input transfer only when in_valid and in_ready are both 1, and an output transfer only when out_valid and out_ready are both 1.
REQ-015 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing col on each input transfer, wrapping col to 0 and incrementing row at IMG_W-1, and wrapping row to 0 at IMG_H-1.
REQ-016 SHALL hold the even-column element in a pair register and, on the odd column, form the horizontal maximum of the pair using signed comparison.
REQ-017 SHALL, on even rows, write each horizontal maximum into a line buffer of IMG_W/2 entries at index col/2.
REQ-018 SHALL, on odd rows at odd columns, load out_data with the signed maximum of the line-buffer entry col/2 and the current horizontal maximum, and set out_valid to 1 on the following clock edge (latency one cycle from accepting the bottom-right element).
REQ-019 SHALL set out_last to 1 together with the output produced at row IMG_H-1, col IMG_W-1, and to 0 with every other output.
REQ-020 SHALL drive in_ready = (!out_valid) || out_ready, combinationally, in every cycle.
REQ-021 SHALL, when an output transfer and a new output load occur in the same cycle, present the new value with out_valid held at 1 and no bubble.
REQ-022 SHALL clear out_valid after an output transfer when no new output loads that cycle.
REQ-023 SHALL hold out_data and out_last stable while out_valid is 1 and out_ready is 0.
REQ-024 SHALL treat equal operands as ties with no preference; the result equals their common value.

Reset
REQ-025 SHALL, while rst is 1 at a clock edge, set col, row, out_valid, out_last and out_data to 0 and discard the pair register; line-buffer contents are not reset.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the first input after reset is treated as row 0, col 0.

Configuration
REQ-027 SHALL, when macro MAXPOOL_FUSED_RELU_EN is defined, load max(pooled value, 0) into out_data, i.e. negative pooled results become 0.
REQ-028 SHALL, when MAXPOOL_FUSED_RELU_EN is undefined, output the signed pooled value unmodified, negatives included.

Verification
REQ-029 SHALL cover: IMG_W=IMG_H=4, inputs 0..15 in raster order, out_ready=1 -> outputs 5,7,13,15 with out_last only on 15.
REQ-030 SHALL cover: a 2x2 block of -128,-3,-7,-50 -> output -3 without MAXPOOL_FUSED_RELU_EN, 0 with it.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles while out_valid=1 -> in_ready=0, out_data unchanged, no inputs lost; all outputs match after release.
REQ-032 SHALL cover: rst asserted after 6 inputs of a 4x4 frame, then a full frame 0..15 -> outputs exactly 5,7,13,15.
REQ-033 SHALL cover: random in_valid/out_ready toggling over three back-to-back 4x4 frames -> output sequence equals a reference model, with out_last on every 4th output.
